// File: rtl/io_mmio_responder.sv
// Memory-mapped IO target: UART transmit/receive bridge plus cycle and
// retired-instruction counters, with registered load data.
module io_mmio_responder #(
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  Addr,
  input  logic [3:0]  StoreMaskIO,
  input  logic [31:0] WriteData,
  input  logic        LoadIO,
  output logic [31:0] ReadData,
  input  logic        InstrRetire,
  output logic [7:0]  UATxData,
  output logic        UATxValid,
  input  logic        UATxReady,
  input  logic [7:0]  UARxData,
  input  logic        UARxValid,
  output logic        UARxReady
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [AW:0] LP_FULL = (AW+1)'(RX_DEPTH);

  typedef enum logic [5:0] {
    REG_TXSTAT = 6'h00,
    REG_RXSTAT = 6'h01,
    REG_TXDATA = 6'h02,
    REG_RXDATA = 6'h03,
    REG_CYCLE  = 6'h04,
    REG_INSTR  = 6'h05
  } reg_e;

  logic [31:0]      r_readData;
  logic [7:0]       r_txData;
  logic             r_txValid;
  logic             r_txOverrun;
  logic [7:0]       r_mem [RX_DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instr;

  logic [5:0]  w_word;
  logic        w_write;
  logic        w_txWrite;
  logic        w_rdTxStat;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_clrCycle;
  logic        w_clrInstr;
  logic [31:0] w_cycleExt;
  logic [31:0] w_instrExt;
  logic [31:0] w_readMux;
  logic        w_unused;

  assign w_word     = Addr[7:2];
  assign w_write    = |StoreMaskIO;
  assign w_txWrite  = w_write && (w_word == REG_TXDATA) && StoreMaskIO[0];
  assign w_rdTxStat = LoadIO && (w_word == REG_TXSTAT);
  assign w_full     = (r_count == LP_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = UARxValid && !w_full;
  assign w_pop      = LoadIO && (w_word == REG_RXDATA) && !w_empty;
  assign w_clrCycle = w_write && (w_word == REG_CYCLE);
  assign w_clrInstr = w_write && (w_word == REG_INSTR);
  assign w_unused   = &{1'b0, Addr[1:0], WriteData[31:8]};

  assign ReadData  = r_readData;
  assign UATxData  = r_txData;
  assign UATxValid = r_txValid;
  assign UARxReady = !w_full;

  always_comb begin
    w_cycleExt = '0;
    w_instrExt = '0;
    w_cycleExt[CNT_W-1:0] = r_cycle;
    w_instrExt[CNT_W-1:0] = r_instr;
  end

  // Read data always reflects pre-edge state, even when a write lands the same cycle.
  always_comb begin
    w_readMux = '0;
    case (w_word)
      REG_TXSTAT: w_readMux = {30'd0, r_txOverrun, !r_txValid};
      REG_RXSTAT: w_readMux = {30'd0, w_full, !w_empty};
      REG_RXDATA: w_readMux = w_empty ? 32'd0 : {24'd0, r_mem[r_rdPtr]};
      REG_CYCLE:  w_readMux = w_cycleExt;
      REG_INSTR:  w_readMux = w_instrExt;
      default:    w_readMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_readData <= '0;
    end else if (LoadIO) begin
      r_readData <= w_readMux;
    end
  end

  // A store arriving while a byte is still pending is dropped and flagged;
  // a coincident TXSTAT read cannot hide that flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txData    <= '0;
      r_txValid   <= 1'b0;
      r_txOverrun <= 1'b0;
    end else begin
      if (w_txWrite && !r_txValid) begin
        r_txData  <= WriteData[7:0];
        r_txValid <= 1'b1;
      end else if (r_txValid && UATxReady) begin
        r_txValid <= 1'b0;
      end
      if (w_txWrite && r_txValid) begin
        r_txOverrun <= 1'b1;
      end else if (w_rdTxStat) begin
        r_txOverrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= UARxData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  // Software clears take priority over the free-running increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= '0;
      r_instr <= '0;
    end else begin
      r_cycle <= w_clrCycle ? '0 : r_cycle + CNT_W'(1);
      if (w_clrInstr) begin
        r_instr <= '0;
      end else if (InstrRetire) begin
        r_instr <= r_instr + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_io_mmio_responder.sv
// Self-checking bench for io_mmio_responder: directed vector table, hand-written
// corner sequences and random traffic compared against a queue-based model.
module tb_io_mmio_responder;

  localparam int RX_DEPTH = 4;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        load;
    logic        txReady;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        retire;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] expRead;
    logic        expTxValid;
    logic [7:0]  expTxData;
    logic        expRxReady;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  Addr;
  logic [3:0]  StoreMaskIO;
  logic [31:0] WriteData;
  logic        LoadIO;
  logic [31:0] ReadData;
  logic        InstrRetire;
  logic [7:0]  UATxData;
  logic        UATxValid;
  logic        UATxReady;
  logic [7:0]  UARxData;
  logic        UARxValid;
  logic        UARxReady;

  logic [7:0]  addr4;
  logic [3:0]  mask4;
  logic        load4;
  logic [31:0] readData4;
  logic [7:0]  txData4;
  logic        txValid4;
  logic        rxReady4;

  int errors = 0;
  int checks = 0;

  logic [31:0] mRead;
  logic        mTxValid;
  logic [7:0]  mTxData;
  logic        mOverrun;
  logic [7:0]  mFifo[$];
  logic [31:0] mCycle;
  logic [31:0] mInstr;

  vec_t vecs[20];

  io_mmio_responder #(.RX_DEPTH(RX_DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .StoreMaskIO(StoreMaskIO),
    .WriteData(WriteData), .LoadIO(LoadIO), .ReadData(ReadData),
    .InstrRetire(InstrRetire), .UATxData(UATxData), .UATxValid(UATxValid),
    .UATxReady(UATxReady), .UARxData(UARxData), .UARxValid(UARxValid),
    .UARxReady(UARxReady)
  );

  // Narrow-counter instance used only to reach the counter wrap point quickly.
  io_mmio_responder #(.RX_DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Addr(addr4), .StoreMaskIO(mask4),
    .WriteData(32'd0), .LoadIO(load4), .ReadData(readData4),
    .InstrRetire(1'b0), .UATxData(txData4), .UATxValid(txValid4),
    .UATxReady(1'b0), .UARxData(8'd0), .UARxValid(1'b0),
    .UARxReady(rxReady4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(input logic [7:0] addr, input logic [3:0] mask,
                                   input logic [31:0] wdata, input logic load,
                                   input logic txReady, input logic rxValid,
                                   input logic [7:0] rxData, input logic retire);
    stim_t s;
    s.addr = addr; s.mask = mask; s.wdata = wdata; s.load = load;
    s.txReady = txReady; s.rxValid = rxValid; s.rxData = rxData; s.retire = retire;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input logic [31:0] expRead,
                                 input logic expTxValid, input logic [7:0] expTxData,
                                 input logic expRxReady);
    vec_t v;
    v.s = s; v.expRead = expRead; v.expTxValid = expTxValid;
    v.expTxData = expTxData; v.expRxReady = expRxReady;
    return v;
  endfunction

  function automatic stim_t idle(input logic txReady);
    return mkStim(8'h00, 4'h0, 32'd0, 1'b0, txReady, 1'b0, 8'h00, 1'b0);
  endfunction

  function automatic stim_t ld(input logic [7:0] addr);
    return mkStim(addr, 4'h0, 32'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endfunction

  function automatic stim_t st(input logic [7:0] addr, input logic [31:0] data);
    return mkStim(addr, 4'hF, data, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endfunction

  task automatic modelReset();
    mRead = '0; mTxValid = 1'b0; mTxData = '0; mOverrun = 1'b0;
    mFifo.delete(); mCycle = '0; mInstr = '0;
  endtask

  // Register-level reference: FIFO is a queue, counters are plain integers.
  task automatic modelStep(input stim_t s);
    logic [5:0]  w;
    logic        wr;
    logic        txw;
    logic [31:0] rv;
    int          n;
    w  = s.addr[7:2];
    wr = |s.mask;
    n  = mFifo.size();
    case (w)
      6'd0:    rv = {30'd0, mOverrun, ~mTxValid};
      6'd1:    rv = {30'd0, (n == RX_DEPTH), (n != 0)};
      6'd3:    rv = (n != 0) ? {24'd0, mFifo[0]} : 32'd0;
      6'd4:    rv = mCycle;
      6'd5:    rv = mInstr;
      default: rv = 32'd0;
    endcase
    if (s.load) mRead = rv;
    txw = wr && (w == 6'd2) && s.mask[0];
    if (txw && mTxValid) mOverrun = 1'b1;
    else if (s.load && w == 6'd0) mOverrun = 1'b0;
    if (txw && !mTxValid) begin
      mTxData = s.wdata[7:0];
      mTxValid = 1'b1;
    end else if (mTxValid && s.txReady) begin
      mTxValid = 1'b0;
    end
    if (s.load && w == 6'd3 && n > 0) void'(mFifo.pop_front());
    if (s.rxValid && n < RX_DEPTH) mFifo.push_back(s.rxData);
    mCycle = (wr && w == 6'd4) ? 32'd0 : mCycle + 32'd1;
    mInstr = (wr && w == 6'd5) ? 32'd0 : mInstr + 32'(s.retire);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " ReadData"}, ReadData, mRead);
    checkOutput({tag, " UATxValid"}, 32'(UATxValid), 32'(mTxValid));
    checkOutput({tag, " UATxData"}, 32'(UATxData), 32'(mTxData));
    checkOutput({tag, " UARxReady"}, 32'(UARxReady), 32'(mFifo.size() < RX_DEPTH));
  endtask

  // Drives one cycle of inputs, advances DUT and model, then samples 1ns after the edge.
  task automatic applyStimulus(input stim_t s, input string tag);
    Addr = s.addr; StoreMaskIO = s.mask; WriteData = s.wdata; LoadIO = s.load;
    UATxReady = s.txReady; UARxValid = s.rxValid; UARxData = s.rxData;
    InstrRetire = s.retire;
    @(posedge clk);
    modelStep(s);
    #1;
    checkModel(tag);
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    addr4 = 8'h00; mask4 = 4'h0; load4 = 1'b0;
    Addr = '0; StoreMaskIO = '0; WriteData = '0; LoadIO = 1'b0;
    UATxReady = 1'b0; UARxValid = 1'b0; UARxData = '0; InstrRetire = 1'b0;
    modelReset();
    #12;
    checkOutput("reset ReadData", ReadData, 32'd0);
    checkOutput("reset UATxValid", 32'(UATxValid), 32'd0);
    checkOutput("reset UATxData", 32'(UATxData), 32'd0);
    checkOutput("reset UARxReady", 32'(UARxReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = mkVec(ld(8'h00), 32'h1, 1'b0, 8'h00, 1'b1);
    vecs[1]  = mkVec(ld(8'h04), 32'h0, 1'b0, 8'h00, 1'b1);
    vecs[2]  = mkVec(mkStim(8'h08, 4'h1, 32'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0), 32'h0, 1'b1, 8'h41, 1'b1);
    vecs[3]  = mkVec(idle(1'b0), 32'h0, 1'b1, 8'h41, 1'b1);
    vecs[4]  = mkVec(mkStim(8'h08, 4'h1, 32'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0), 32'h0, 1'b1, 8'h41, 1'b1);
    vecs[5]  = mkVec(idle(1'b0), 32'h0, 1'b1, 8'h41, 1'b1);
    vecs[6]  = mkVec(idle(1'b1), 32'h0, 1'b0, 8'h41, 1'b1);
    vecs[7]  = mkVec(ld(8'h00), 32'h3, 1'b0, 8'h41, 1'b1);
    vecs[8]  = mkVec(ld(8'h00), 32'h1, 1'b0, 8'h41, 1'b1);
    vecs[9]  = mkVec(mkStim(8'h00, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0), 32'h1, 1'b0, 8'h41, 1'b1);
    vecs[10] = mkVec(mkStim(8'h00, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0), 32'h1, 1'b0, 8'h41, 1'b1);
    vecs[11] = mkVec(mkStim(8'h00, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0), 32'h1, 1'b0, 8'h41, 1'b1);
    vecs[12] = mkVec(mkStim(8'h00, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0), 32'h1, 1'b0, 8'h41, 1'b0);
    vecs[13] = mkVec(mkStim(8'h04, 4'h0, 32'd0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0), 32'h3, 1'b0, 8'h41, 1'b0);
    vecs[14] = mkVec(ld(8'h0C), 32'h11, 1'b0, 8'h41, 1'b1);
    vecs[15] = mkVec(ld(8'h0C), 32'h22, 1'b0, 8'h41, 1'b1);
    vecs[16] = mkVec(ld(8'h0C), 32'h33, 1'b0, 8'h41, 1'b1);
    vecs[17] = mkVec(ld(8'h0C), 32'h44, 1'b0, 8'h41, 1'b1);
    vecs[18] = mkVec(ld(8'h0C), 32'h0, 1'b0, 8'h41, 1'b1);
    vecs[19] = mkVec(ld(8'h04), 32'h0, 1'b0, 8'h41, 1'b1);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].s, $sformatf("vec%0d model", i));
      checkOutput($sformatf("vec%0d ReadData", i), ReadData, vecs[i].expRead);
      checkOutput($sformatf("vec%0d UATxValid", i), 32'(UATxValid), 32'(vecs[i].expTxValid));
      checkOutput($sformatf("vec%0d UATxData", i), 32'(UATxData), 32'(vecs[i].expTxData));
      checkOutput($sformatf("vec%0d UARxReady", i), 32'(UARxReady), 32'(vecs[i].expRxReady));
    end

    // Simultaneous push and pop with two entries held.
    applyStimulus(mkStim(8'h00, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0), "pp push1");
    applyStimulus(mkStim(8'h00, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0), "pp push2");
    applyStimulus(mkStim(8'h0C, 4'h0, 32'd0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0), "pp both");
    checkOutput("pushpop oldest", ReadData, 32'hA1);
    applyStimulus(ld(8'h04), "pp stat");
    checkOutput("pushpop rxstat", ReadData, 32'h1);
    applyStimulus(ld(8'h0C), "pp pop2");
    checkOutput("pushpop second", ReadData, 32'hA2);
    applyStimulus(ld(8'h0C), "pp pop3");
    checkOutput("pushpop third", ReadData, 32'hA3);
    applyStimulus(ld(8'h0C), "pp empty");
    checkOutput("pushpop drained", ReadData, 32'h0);

    // Cycle counter: clear, five idle edges, then read.
    applyStimulus(st(8'h10, 32'hDEAD_BEEF), "cyc clear");
    for (int i = 0; i < 5; i++) applyStimulus(idle(1'b0), "cyc idle");
    applyStimulus(ld(8'h10), "cyc read");
    checkOutput("cycle after clear", ReadData, 32'd5);

    // Instruction counter: seven retire pulses separated by idle cycles.
    applyStimulus(st(8'h14, 32'h1234), "ins clear");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(mkStim(8'h00, 4'h0, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1), "ins pulse");
      applyStimulus(idle(1'b0), "ins idle");
    end
    applyStimulus(ld(8'h14), "ins read");
    checkOutput("instr count", ReadData, 32'd7);

    // Counter wrap on the 4-bit instance: reaches all ones, then rolls to zero.
    addr4 = 8'h10; mask4 = 4'h1; load4 = 1'b0;
    applyStimulus(idle(1'b0), "wrap clear");
    mask4 = 4'h0;
    for (int i = 0; i < 15; i++) applyStimulus(idle(1'b0), "wrap idle");
    load4 = 1'b1;
    applyStimulus(idle(1'b0), "wrap read1");
    checkOutput("cycle all ones", readData4, 32'hF);
    applyStimulus(idle(1'b0), "wrap read2");
    checkOutput("cycle wrap", readData4, 32'h0);
    load4 = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      logic [5:0] w;
      w = 6'($urandom_range(0, 7));
      s.addr    = ($urandom_range(0, 15) == 0) ? 8'($urandom) : {w, 2'($urandom)};
      s.mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      s.wdata   = $urandom;
      s.load    = 1'($urandom);
      s.txReady = ($urandom_range(0, 2) == 0);
      s.rxValid = 1'($urandom);
      s.rxData  = 8'($urandom);
      s.retire  = 1'($urandom);
      applyStimulus(s, $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a pending transmit.
    applyStimulus(mkStim(8'h08, 4'h1, 32'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0), "rst store");
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset UATxValid", 32'(UATxValid), 32'd0);
    checkOutput("async reset ReadData", ReadData, 32'd0);
    checkOutput("async reset UARxReady", 32'(UARxReady), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(ld(8'h10), "post cyc");
    checkOutput("post reset cycle", ReadData, 32'd0);
    applyStimulus(ld(8'h14), "post ins");
    checkOutput("post reset instr", ReadData, 32'd0);
    applyStimulus(ld(8'h04), "post rx");
    checkOutput("post reset rxstat", ReadData, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_mmio_responder.md
Name: io_mmio_responder

Overview:
- Target side of the CPU's memory-mapped IO region (TopAddr 4'b1000, i.e. 0x8xxx_xxxx).
- Consumes the IO store mask and load strobe from the CPU memory stage and returns registered read data, to be selected when LoadDMEMorIO=1.
- Bridges those accesses to the UART byte-stream handshakes.
- Holds the cycle and retired-instruction counters.

Parameters:
- RX_DEPTH, 4, receive FIFO entries (power of two, ≥2).
- CNT_W, 32, counter width (≤32; reads zero-extended).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Addr  in  8  byte address bits [7:0] of the IO access; bits [1:0] ignored.
- StoreMaskIO  in  4  byte write enables for the IO region; all zero means no write.
- WriteData  in  32  store data.
- LoadIO  in  1  load strobe, qualified by the CPU with the IO region decode.
- ReadData  out  32  load result, valid the cycle after LoadIO.
- InstrRetire  in  1  one pulse per retired instruction.
- UATxData  out  8  byte to transmitter.
- UATxValid  out  1  transmit byte valid.
- UATxReady  in  1  transmitter accepts byte.
- UARxData  in  8  received byte.
- UARxValid  in  1  received byte valid.
- UARxReady  out  1  receive FIFO can accept a byte.

Behaviour:
- Register map (word offset Addr[7:2]):
  - 0x00 TXSTAT R: bit0 = ~UATxValid, bit1 = TxOverrun (sticky).
  - 0x04 RXSTAT R: bit0 = FIFO not empty, bit1 = FIFO full.
  - 0x08 TXDATA W: byte from WriteData[7:0].
  - 0x0C RXDATA R: head byte, zero-extended; the read pops the FIFO.
  - 0x10 CYCLE R/W.
  - 0x14 INSTR R/W.
  - Other offsets: read 0; writes ignored.
- Reset (rst_n=0, asynchronous):
  - ReadData=0, UATxValid=0, UATxData=0, UARxReady=1.
  - FIFO pointers and count = 0; TxOverrun = 0; both counters = 0.
- Read latency:
  - ReadData is registered. It captures the selected register value at the edge where LoadIO=1.
  - ReadData holds its value until the next load.
- Transmit:
  - Write to TXDATA with StoreMaskIO[0]=1 and UATxValid=0: at the edge, UATxData ← WriteData[7:0] and UATxValid ← 1.
  - UATxValid stays high until an edge with UATxReady=1; it clears at that edge.
  - Write while UATxValid=1: byte dropped, TxOverrun ← 1. This includes the handshake-completion cycle.
  - Reading TXSTAT clears TxOverrun at that edge. The read returns the pre-clear value.
  - If a set and a clear of TxOverrun occur at the same edge, the set wins.
- Receive FIFO:
  - UARxReady = ~full, combinational from the count.
  - Push at the edge where UARxValid & UARxReady.
  - Pop at the edge of a LoadIO read of RXDATA when not empty.
  - Read of RXDATA when empty returns 0 and pointers are unchanged.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - When full, no push is possible, so a pop that cycle just frees an entry.
  - Pointers wrap modulo RX_DEPTH. The count runs 0..RX_DEPTH.
- Counters:
  - CYCLE increments every cycle.
  - INSTR increments at each edge where InstrRetire=1.
  - Both wrap at 2^CNT_W.
  - A write with any StoreMaskIO bit set clears the addressed counter to 0 at that edge; the clear wins over the increment. The write data is ignored.
  - A read returns the value before that edge's update.
- Simultaneous LoadIO and a nonzero StoreMaskIO: the write is performed and the read data is captured from the pre-write state. The CPU does not issue both, but this behaviour is defined.
- Reset mid-operation: a pending TX byte is discarded (UATxValid drops immediately) and FIFO contents are lost.

Test Plan:
- Reset, then LoadIO on 0x00 and on 0x04 -> ReadData 0x1 and 0x0 respectively; UARxReady=1, UATxValid=0.
- Store 0x41 to 0x08 with UATxReady=0 for 3 cycles, then 1 -> UATxValid high 4 cycles with UATxData=0x41. A second store during the wait sets TXSTAT=0x3; the next TXSTAT read returns 0x3 and the one after returns 0x1.
- Push 0x11, 0x22, 0x33, 0x44 -> UARxReady=0 and RXSTAT=0x3. A fifth byte is held off. Four RXDATA reads return 0x11..0x44 in order; a further read returns 0 and RXSTAT=0.
- With the FIFO at count 2: push and pop in the same cycle -> count stays 2, order is preserved, and the popped byte is the oldest.
- Store to 0x10, wait 5 cycles, load 0x10 -> ReadData=5 with the load issued 5 edges after the clear. Force CYCLE to 0xFFFFFFFF and check it wraps to 0.
- Pulse InstrRetire 7 times interleaved with idle cycles, then load 0x14 -> 7. Assert rst_n=0 asynchronously mid-TX -> UATxValid=0 within the reset window and all counters read 0.
